disp_chan_mux: RTL

Parametrised display-channel multiplexer feeding the seven-segment driver. It selects one of N_CH data channels or a register-file read-back word for display. Channel 0 is a CPU-writable latch. An optional auto-scan mode rotates through all channels at a programmable dwell period. The output is registered and sits between the CPU/test-data sources and the seg7 driver.

---
 rtl/disp_pkg.sv | 9 +
 rtl/disp_chan_mux_if.sv | 25 ++
 rtl/disp_scan_ctr.sv | 48 ++++
 rtl/disp_chan_mux.sv | 121 ++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and types for the display-channel multiplexer.
package disp_pkg;
  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} disp_state_e;

  localparam int                MAX_DW       = 256;
  localparam logic [MAX_DW-1:0] FILL_PATTERN = '1;
  localparam logic [4:0]        CH_IDX_NONE  = 5'h1F;
  localparam logic [31:0]       DEFAULT0_C   = 32'hAA5555AA;
endpackage

// File: rtl/disp_chan_mux_if.sv
// CPU / test-data side bundle of the display multiplexer plus its seg7-facing outputs.
interface disp_chan_mux_if #(
  parameter int N_CH = 8,
  parameter int DW   = 32
);
  logic                   en;
  logic [DW-1:0]          wdata;
  logic [5:0]             ctrl;
  logic [(N_CH-1)*DW-1:0] ch_data;
  logic [DW-1:0]          reg_data;
  logic                   scan;
  logic                   hold;
  logic [DW-1:0]          seg7_data;
  logic [4:0]             ch_idx;

  modport master (
    output en, wdata, ctrl, ch_data, reg_data, scan, hold,
    input  seg7_data, ch_idx
  );

  modport slave (
    input  en, wdata, ctrl, ch_data, reg_data, scan, hold,
    output seg7_data, ch_idx
  );
endinterface

// File: rtl/disp_scan_ctr.sv
// Dwell prescaler and channel index counter for auto-scan mode.
// idx_nxt_o exposes the value idx_o takes at the next edge so the display can follow it without extra latency.
module disp_scan_ctr #(
  parameter int N_CH     = 8,
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       hold,
  input  logic       tick_en,
  output logic [4:0] idx_o,
  output logic [4:0] idx_nxt_o
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (clr) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (tick_en && !hold) begin
      if (cnt_q == CW'(SCAN_DIV - 1)) begin
        cnt_d = '0;
        idx_d = (idx_q == 5'(N_CH - 1)) ? 5'd0 : idx_q + 5'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx_o     = idx_q;
  assign idx_nxt_o = idx_d;
endmodule

// File: rtl/disp_chan_mux.sv
// Display-channel multiplexer: channel-0 CPU latch, manual select, registered seg7 word.
// Auto-scan (SCAN state + disp_scan_ctr) is built only when DISP_AUTOSCAN_EN is defined.
module disp_chan_mux
  import disp_pkg::*;
#(
  parameter int          N_CH     = 8,
  parameter int          DW       = 32,
  parameter int          SCAN_DIV = 50_000_000,
  parameter logic [31:0] DEFAULT0 = DEFAULT0_C
) (
  input logic             clk,
  input logic             rst,
  disp_chan_mux_if.slave  bus
);
  localparam logic [DW-1:0] DEF0 = DW'(DEFAULT0);
  localparam logic [DW-1:0] FILL = FILL_PATTERN[DW-1:0];

  if (N_CH < 2 || N_CH > 32) begin : g_bad_nch
    $error("disp_chan_mux: N_CH out of range");
  end
  if (SCAN_DIV < 2) begin : g_bad_div
    $error("disp_chan_mux: SCAN_DIV must be at least 2");
  end

  logic [DW-1:0]            ch0_q, ch0_d;
  logic [DW-1:0]            seg_q, seg_d;
  logic [4:0]               idx_q, idx_d;
  logic [N_CH-1:0][DW-1:0]  ch_arr;
  logic [DW-1:0]            man_data, nxt_data;
  logic [4:0]               man_idx, nxt_idx;

  // Channel k of ch_data sits at [k*DW-1 -: DW], so prepending the latch lines everything up by index.
  assign ch_arr = {bus.ch_data, ch0_q};

  always_comb begin
    man_data = FILL;
    man_idx  = CH_IDX_NONE;
    if (bus.ctrl[5]) begin
      man_data = bus.reg_data;
    end else if ({1'b0, bus.ctrl[4:0]} < 6'(N_CH)) begin
      man_idx = bus.ctrl[4:0];
      for (int k = 0; k < N_CH; k++)
        if (bus.ctrl[4:0] == 5'(k)) man_data = ch_arr[k];
    end
  end

`ifdef DISP_AUTOSCAN_EN
  disp_state_e state_q, state_d;
  logic [4:0]  scan_idx, scan_idx_nxt;
  logic [DW-1:0] scan_data;

  // Counters sit at zero while in MANUAL, so every entry starts at channel 0 with a fresh dwell.
  disp_scan_ctr #(.N_CH(N_CH), .SCAN_DIV(SCAN_DIV)) u_scan_ctr (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == MANUAL),
    .hold      (bus.hold),
    .tick_en   (state_q == SCAN),
    .idx_o     (scan_idx),
    .idx_nxt_o (scan_idx_nxt)
  );

  logic unused_scan_idx;
  assign unused_scan_idx = ^scan_idx;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MANUAL:  if (bus.scan && !bus.ctrl[5]) state_d = SCAN;
      SCAN:    if (!bus.scan || bus.ctrl[5]) state_d = MANUAL;
      default: state_d = MANUAL;
    endcase
  end

  always_comb begin
    scan_data = '0;
    for (int k = 0; k < N_CH; k++)
      if (scan_idx_nxt == 5'(k)) scan_data = ch_arr[k];
  end

  always_comb begin
    nxt_data = (state_d == SCAN) ? scan_data    : man_data;
    nxt_idx  = (state_d == SCAN) ? scan_idx_nxt : man_idx;
  end
`else
  logic unused_scan;
  assign unused_scan = bus.scan;

  always_comb begin
    nxt_data = man_data;
    nxt_idx  = man_idx;
  end
`endif

  always_comb begin
    ch0_d = bus.en   ? bus.wdata : ch0_q;
    seg_d = bus.hold ? seg_q     : nxt_data;
    idx_d = bus.hold ? idx_q     : nxt_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch0_q   <= DEF0;
      seg_q   <= DEF0;
      idx_q   <= '0;
`ifdef DISP_AUTOSCAN_EN
      state_q <= MANUAL;
`endif
    end else begin
      ch0_q   <= ch0_d;
      seg_q   <= seg_d;
      idx_q   <= idx_d;
`ifdef DISP_AUTOSCAN_EN
      state_q <= state_d;
`endif
    end
  end

  assign bus.seg7_data = seg_q;
  assign bus.ch_idx    = idx_q;
endmodule
